// File: rtl/pbkdf2_2_out_ser.sv
// Output serializer for the PBKDF2-2 digest: captures one result per controller valid
// and streams it MSW-first as NUM_WORDS words over a valid/ready interface.
module pbkdf2_2_out_ser #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 8,
    parameter bit          BYTE_SWAP = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pbkdf2_valid,
    input  logic [WORD_W*NUM_WORDS-1:0] pbkdf2_digest,
    output logic                        digest_ack,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned DIGEST_W = WORD_W * NUM_WORDS;
    localparam int unsigned CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned NBYTES   = WORD_W / 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DROP = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [DIGEST_W-1:0]  hold_reg, hold_nxt;
    logic [CNT_W-1:0]     word_cnt, cnt_nxt;
    logic [WORD_W-1:0]    data_nxt;
    logic                 valid_nxt, last_nxt, ack_nxt, busy_nxt, overrun_nxt;
    logic                 valid_q;
    logic                 handshake;
    logic                 at_last;

    // Select word idx (MSW first), optionally byte-reversed.
    function automatic logic [WORD_W-1:0] pick_word(input logic [DIGEST_W-1:0] d,
                                                    input logic [CNT_W-1:0]    idx);
        logic [DIGEST_W-1:0] sh;
        logic [WORD_W-1:0]   w;
        logic [WORD_W-1:0]   r;
        sh = d << (WORD_W * 32'(idx));
        w  = sh[DIGEST_W-1 -: WORD_W];
        r  = w;
        if (BYTE_SWAP) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                r[8*b +: 8] = w[WORD_W-1-8*b -: 8];
            end
        end
        return r;
    endfunction

    assign handshake = out_valid & out_ready;
    assign at_last   = (word_cnt == LAST_IDX);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_reg   <= '0;
            word_cnt   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            digest_ack <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_reg   <= hold_nxt;
            word_cnt   <= cnt_nxt;
            out_data   <= data_nxt;
            out_valid  <= valid_nxt;
            out_last   <= last_nxt;
            digest_ack <= ack_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            valid_q    <= pbkdf2_valid;
        end
    end

    // Next state; after the last word, a still-high valid is a result already sent.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (pbkdf2_valid) state_nxt = S_SEND;
            S_SEND: begin
                if (handshake && at_last) begin
                    state_nxt = pbkdf2_valid ? S_WAIT_DROP : S_IDLE;
                end
            end
            S_WAIT_DROP: if (!pbkdf2_valid) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Next values of the datapath and output registers.
    always_comb begin
        hold_nxt    = hold_reg;
        cnt_nxt     = word_cnt;
        data_nxt    = out_data;
        valid_nxt   = out_valid;
        last_nxt    = out_last;
        ack_nxt     = 1'b0;
        overrun_nxt = overrun;
        busy_nxt    = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (pbkdf2_valid) begin
                    hold_nxt  = pbkdf2_digest;
                    cnt_nxt   = '0;
                    data_nxt  = pick_word(pbkdf2_digest, '0);
                    valid_nxt = 1'b1;
                    last_nxt  = (LAST_IDX == '0);
                    ack_nxt   = 1'b1;
                end
            end
            S_SEND: begin
                if (pbkdf2_valid && !valid_q) overrun_nxt = 1'b1;
                if (handshake) begin
                    if (at_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        data_nxt  = '0;
                    end else begin
                        cnt_nxt  = word_cnt + CNT_W'(1);
                        data_nxt = pick_word(hold_reg, word_cnt + CNT_W'(1));
                        last_nxt = ((word_cnt + CNT_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

endmodule
